// File: rtl/isa_pkg.sv
// Shared types and constants for the ISA bus initiator: FSM states,
// strobe-select encoding ({io, write}) and the floating-bus read value.
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD,
    ST_RESP
  } isa_state_e;

  typedef enum logic [1:0] {
    SEL_MEMR = 2'b00,
    SEL_MEMW = 2'b01,
    SEL_IOR  = 2'b10,
    SEL_IOW  = 2'b11
  } isa_sel_e;

  localparam logic [7:0] ISA_FLOAT_DATA = 8'hFF;

  // Strobe vector ordering is {ior_l, iow_l, memr_l, memw_l}
  localparam logic [3:0] STROBES_IDLE = 4'b1111;

  function automatic logic [3:0] strobe_lines(input isa_sel_e sel);
    case (sel)
      SEL_IOR:  strobe_lines = 4'b0111;
      SEL_IOW:  strobe_lines = 4'b1011;
      SEL_MEMR: strobe_lines = 4'b1101;
      default:  strobe_lines = 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter with zero flag; one instance times every bus phase.
module isa_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/isa_bus_initiator.sv
// ISA bus cycle initiator: SETUP -> STROBE -> (WAIT) -> HOLD -> RESP.
// Define ISA_BUS_TIMEOUT_EN to abort wait states after TIMEOUT_CYC cycles.
module isa_bus_initiator
  import isa_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_din,
  input  logic        bus_dir,
  input  logic        bus_rdy,
  output logic        bus_aen
);

  // Phase lengths are assumed >= 1; the timer is loaded with length-1.
  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_ST  = (STROBE_CYC > TIMEOUT_CYC) ? STROBE_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_SH > MAX_ST) ? MAX_SH : MAX_ST;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] LD_SETUP  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_STROBE = TMR_W'(STROBE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_HOLD   = TMR_W'(HOLD_CYC - 1);

  isa_state_e       r_state;
  isa_sel_e         r_sel;
  logic [3:0]       r_strobe_n;
  logic [19:0]      r_bus_a;
  logic [7:0]       r_bus_d;
  logic             r_bus_d_oe;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic [7:0]       r_rdata_cap;

  logic             w_accept;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_value;
  logic             w_tmr_zero;
  logic [7:0]       w_bus_sample;

  assign w_accept     = req_valid & r_req_ready;
  assign w_bus_sample = bus_dir ? bus_din : ISA_FLOAT_DATA;

  isa_cycle_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  // Timer reload at every phase boundary the FSM below takes
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_tmr_load  = 1'b1;
        w_tmr_value = LD_SETUP;
      end
      ST_SETUP: if (w_tmr_zero) begin
        w_tmr_load  = 1'b1;
        w_tmr_value = LD_STROBE;
      end
      ST_STROBE: if (w_tmr_zero) begin
        w_tmr_load  = 1'b1;
`ifdef ISA_BUS_TIMEOUT_EN
        w_tmr_value = bus_rdy ? LD_HOLD : TMR_W'(TIMEOUT_CYC - 1);
`else
        w_tmr_value = LD_HOLD;
`endif
      end
      ST_WAIT: begin
`ifdef ISA_BUS_TIMEOUT_EN
        w_tmr_load = bus_rdy | w_tmr_zero;
`else
        w_tmr_load = bus_rdy;
`endif
        w_tmr_value = LD_HOLD;
      end
      default: ;
    endcase
  end

`ifdef ISA_BUS_TIMEOUT_EN
  logic r_timed_out;
  logic r_rsp_timeout;
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_MEMR;
      r_strobe_n  <= STROBES_IDLE;
      r_bus_a     <= '0;
      r_bus_d     <= '0;
      r_bus_d_oe  <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rdata_cap <= '0;
`ifdef ISA_BUS_TIMEOUT_EN
      r_timed_out   <= 1'b0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_req_ready <= 1'b0;
          r_sel       <= isa_sel_e'({req_io, req_write});
          r_bus_a     <= req_addr;
          r_bus_d_oe  <= req_write;
          if (req_write) r_bus_d <= req_wdata;
`ifdef ISA_BUS_TIMEOUT_EN
          r_timed_out <= 1'b0;
`endif
          r_state     <= ST_SETUP;
        end
        ST_SETUP: if (w_tmr_zero) begin
          r_strobe_n <= strobe_lines(r_sel);
          r_state    <= ST_STROBE;
        end
        ST_STROBE: if (w_tmr_zero) begin
          if (bus_rdy) begin
            r_strobe_n  <= STROBES_IDLE;
            r_rdata_cap <= w_bus_sample;
            r_state     <= ST_HOLD;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_rdy) begin
            r_strobe_n  <= STROBES_IDLE;
            r_rdata_cap <= w_bus_sample;
            r_state     <= ST_HOLD;
          end
`ifdef ISA_BUS_TIMEOUT_EN
          else if (w_tmr_zero) begin
            r_strobe_n  <= STROBES_IDLE;
            r_rdata_cap <= ISA_FLOAT_DATA;
            r_timed_out <= 1'b1;
            r_state     <= ST_HOLD;
          end
`endif
        end
        ST_HOLD: if (w_tmr_zero) begin
          r_bus_d_oe  <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_sel[0] ? 8'h00 : r_rdata_cap;
`ifdef ISA_BUS_TIMEOUT_EN
          r_rsp_timeout <= r_timed_out;
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign bus_a      = r_bus_a;
  assign bus_d      = r_bus_d;
  assign bus_d_oe   = r_bus_d_oe;
  assign bus_ior_l  = r_strobe_n[3];
  assign bus_iow_l  = r_strobe_n[2];
  assign bus_memr_l = r_strobe_n[1];
  assign bus_memw_l = r_strobe_n[0];
  assign bus_aen    = 1'b0;

endmodule

// File: tb/tb_isa_bus_initiator.sv
// Self-checking bench for isa_bus_initiator: directed cases plus random
// transactions against a cycle-count model of the bus protocol.
module tb_isa_bus_initiator;

  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 4;
  localparam int HOLD_CYC    = 2;
  localparam int TIMEOUT_CYC = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [19:0] bus_a;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
  logic [7:0]  bus_d, bus_din;
  logic        bus_d_oe, bus_dir, bus_rdy, bus_aen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  isa_bus_initiator #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_a(bus_a),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_d(bus_d), .bus_d_oe(bus_d_oe),
    .bus_din(bus_din), .bus_dir(bus_dir),
    .bus_rdy(bus_rdy), .bus_aen(bus_aen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // wait_n: cycles the target holds bus_rdy low beyond the base strobe width.
  // Target drives bus_din = din_base + step*k on the k-th strobe cycle, so the
  // captured value pins down which cycle the initiator sampled.
  task automatic run_txn(input string name, input bit io, input bit wr,
                         input logic [19:0] addr, input logic [7:0] wdata,
                         input int wait_n, input bit dir,
                         input logic [7:0] din_base, input bit din_step,
                         input bit hold_valid);
    logic [3:0] lines, exp_lines;
    logic [7:0] exp_rdata, rdata_got;
    bit exp_tmo, tmo_got;
    bit bad_lines, bad_a, bad_d, bad_aen, bad_ready;
    int exp_len, exp_lat, cyc, k, rsp_cyc, rsp_cnt;

`ifdef ISA_BUS_TIMEOUT_EN
    exp_tmo = (wait_n > TIMEOUT_CYC);
    exp_len = STROBE_CYC + (exp_tmo ? TIMEOUT_CYC : wait_n);
`else
    exp_tmo = 1'b0;
    exp_len = STROBE_CYC + wait_n;
`endif
    exp_lat = SETUP_CYC + exp_len + HOLD_CYC + 1;
    if (wr)            exp_rdata = 8'h00;
    else if (exp_tmo)  exp_rdata = 8'hFF;
    else if (!dir)     exp_rdata = 8'hFF;
    else               exp_rdata = din_base + (din_step ? 8'(exp_len) : 8'h00);
    exp_lines = 4'b1111;
    exp_lines[io ? (wr ? 2 : 3) : (wr ? 0 : 1)] = 1'b0;

    bad_lines = 0; bad_a = 0; bad_d = 0; bad_aen = 0; bad_ready = 0;
    k = 0; cyc = 0; rsp_cyc = -1; rsp_cnt = 0; rdata_got = 8'h00; tmo_got = 0;

    @(negedge clk);
    check({name, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_io = io; req_write = wr;
    req_addr = addr; req_wdata = wdata;
    bus_dir = dir; bus_rdy = 1'b0;

    while (cyc < 700 && !(rsp_cyc >= 0 && cyc > rsp_cyc + 2)) begin
      @(negedge clk);
      cyc++;
      // Fields change after acceptance; held valid must be ignored while busy
      req_valid = hold_valid && (cyc < exp_lat);
      req_io    = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = 20'($urandom);
      req_wdata = 8'($urandom);
      lines = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};
      if (bus_aen !== 1'b0) bad_aen = 1;
      if (cyc <= exp_lat - 1) begin
        if (bus_a !== addr) bad_a = 1;
        if (bus_d_oe !== wr || (wr && bus_d !== wdata)) bad_d = 1;
        if (req_ready !== 1'b0) bad_ready = 1;
      end else if (cyc == exp_lat) begin
        if (bus_d_oe !== 1'b0 || req_ready !== 1'b0) bad_d = 1;
      end else if (cyc == exp_lat + 1) begin
        if (req_ready !== 1'b1) bad_ready = 1;
      end
      if (lines != 4'b1111) begin
        k++;
        if (lines !== exp_lines) bad_lines = 1;
        bus_rdy = (k >= STROBE_CYC + wait_n);
        bus_din = din_base + (din_step ? 8'(k) : 8'h00);
      end else begin
        bus_rdy = 1'b0;
        bus_din = 8'($urandom);
      end
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc   = cyc;
          rdata_got = rsp_rdata;
          tmo_got   = rsp_timeout;
        end
      end
    end
    req_valid = 1'b0;

    check({name, ".rsp_seen"},   32'(rsp_cyc >= 0), 32'd1);
    check({name, ".latency"},    32'(rsp_cyc), 32'(exp_lat));
    check({name, ".rsp_pulses"}, 32'(rsp_cnt), 32'd1);
    check({name, ".strobe_len"}, 32'(k), 32'(exp_len));
    check({name, ".strobe_sel"}, 32'(bad_lines), 32'd0);
    check({name, ".addr_hold"},  32'(bad_a), 32'd0);
    check({name, ".data_oe"},    32'(bad_d), 32'd0);
    check({name, ".ready"},      32'(bad_ready), 32'd0);
    check({name, ".aen"},        32'(bad_aen), 32'd0);
    check({name, ".rdata"},      32'(rdata_got), 32'(exp_rdata));
    check({name, ".timeout"},    32'(tmo_got), 32'(exp_tmo));
  endtask

  task automatic reset_mid_strobe();
    int k, cyc, rsp_cnt;
    k = 0; cyc = 0; rsp_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_io = 1'b1; req_write = 1'b0; req_addr = 20'h003DA;
    bus_rdy = 1'b1; bus_dir = 1'b1;
    while (k < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if ({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} != 4'b1111) k++;
    end
    check("rst.reached_strobe2", 32'(k), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst.strobes_high", 32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.d_oe", 32'(bus_d_oe), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) rsp_cnt++;
      @(negedge clk);
    end
    check("rst.no_rsp", 32'(rsp_cnt), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; bus_din = '0; bus_dir = 1'b0; bus_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.strobes", 32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
    check("reset.outs", 32'({bus_d_oe, rsp_valid, rsp_timeout, req_ready, bus_aen}), 32'b00010);
    check("reset.bus_a", 32'(bus_a), 32'd0);
    check("reset.bus_d_rdata", 32'({bus_d, rsp_rdata}), 32'd0);
    reset = 1'b0;

    run_txn("io_wr_3d8", 1, 1, 20'h003D8, 8'h29, 0, 1, 8'h00, 0, 0);
    run_txn("io_rd_3da", 1, 0, 20'h003DA, 8'h00, 0, 1, 8'hF9, 0, 0);
    run_txn("mem_rd_wait6", 0, 0, 20'hB8000, 8'h00, 6, 1, 8'h40, 1, 0);
    run_txn("rd_float", 0, 0, 20'h12345, 8'h00, 2, 0, 8'h5A, 1, 0);
    run_txn("mem_wr_wait3", 0, 1, 20'hA0001, 8'hC3, 3, 1, 8'h00, 0, 1);
`ifdef ISA_BUS_TIMEOUT_EN
    run_txn("tmo_never_rdy", 0, 0, 20'h0BEEF, 8'h00, 1000, 1, 8'h10, 1, 0);
    run_txn("tmo_edge_rdy", 1, 0, 20'h00300, 8'h00, TIMEOUT_CYC, 1, 8'h20, 1, 0);
`else
    run_txn("long_wait", 0, 0, 20'h0BEEF, 8'h00, 300, 1, 8'h10, 1, 0);
`endif
    reset_mid_strobe();

    for (int i = 0; i < 20; i++) begin
      run_txn($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), 20'($urandom),
              8'($urandom), int'($urandom_range(0, 8)), 1'($urandom),
              8'($urandom), 1'b1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
